fpu_fetch_sequencer: RTL and testbench

Instruction fetch and issue sequencer for the bfloat16 FPU test core. It starts when the UART/ICCM loader finishes, then fetches 32-bit words from the SRAM read port and presents each word to the decoder for exactly one cycle. For multi-cycle FPU operations it waits for the completion pulse before advancing. It stops on a halt instruction, at the end of program memory, or when the watchdog expires.

---
 rtl/fpu_fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fpu_fetch_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fetch_sequencer.sv
// Instruction fetch/issue sequencer for the bfloat16 FPU test core.
// Fetches words from SRAM, issues each for one cycle, waits on multi-cycle FPU ops.
module fpu_fetch_sequencer #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] HALT_INSN = 32'h0010_0073,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       insn,
   output logic              insn_valid,
   input  logic              stall,
   input  logic              fpu_done,
   output logic [31:0]       pc,
   output logic              running,
   output logic              halted,
   output logic              timeout_err
);

   localparam int unsigned CNT_W = 8;
   localparam logic [ADDR_W-1:0] LAST_WORD = '1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      READ,
      ISSUE,
      CHECK,
      WAIT_DONE,
      HALTED
   } state_t;

   state_t             state, state_nxt;
   logic [31:0]        pc_nxt;
   logic [31:0]        insn_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CNT_W-1:0]   cnt_inc_c;
   logic               halted_nxt;
   logic               timeout_nxt;
   logic               advance_c;

   assign cnt_inc_c = cnt + CNT_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and datapath next values
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      insn_nxt    = insn;
      cnt_nxt     = cnt;
      halted_nxt  = halted;
      timeout_nxt = timeout_err;
      advance_c   = 1'b0;

      case (state)
         IDLE, HALTED: begin
            if (start) begin
               state_nxt   = FETCH;
               pc_nxt      = '0;
               halted_nxt  = 1'b0;
               timeout_nxt = 1'b0;
            end
         end
         FETCH: state_nxt = READ;
         READ: begin
            insn_nxt = mem_rdata;
            if (mem_rdata == HALT_INSN) begin
               state_nxt  = HALTED;
               halted_nxt = 1'b1;
            end else begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = CHECK;
         CHECK: begin
            if (stall) begin
               cnt_nxt   = '0;
               state_nxt = WAIT_DONE;
            end else begin
               advance_c = 1'b1;
            end
         end
         WAIT_DONE: begin
            // Completion wins over a watchdog expiry in the same cycle
            if (fpu_done) begin
               advance_c = 1'b1;
            end else begin
               cnt_nxt = cnt_inc_c;
               if (cnt_inc_c == CNT_W'(TIMEOUT)) begin
                  timeout_nxt = 1'b1;
                  state_nxt   = HALTED;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Stop at the last word instead of wrapping; pc keeps the last address
      if (advance_c) begin
         if (pc[ADDR_W+1:2] == LAST_WORD) begin
            state_nxt  = HALTED;
            halted_nxt = 1'b1;
         end else begin
            pc_nxt    = pc + 32'd4;
            state_nxt = FETCH;
         end
      end
   end

   // Datapath and registered outputs, decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= '0;
         insn        <= '0;
         cnt         <= '0;
         halted      <= 1'b0;
         timeout_err <= 1'b0;
         mem_en      <= 1'b0;
         mem_addr    <= '0;
         insn_valid  <= 1'b0;
         running     <= 1'b0;
      end else begin
         pc          <= pc_nxt;
         insn        <= insn_nxt;
         cnt         <= cnt_nxt;
         halted      <= halted_nxt;
         timeout_err <= timeout_nxt;
         mem_en      <= (state_nxt == FETCH);
         mem_addr    <= pc_nxt[ADDR_W+1:2];
         insn_valid  <= (state_nxt == ISSUE);
         running     <= (state_nxt != IDLE) && (state_nxt != HALTED);
      end
   end

endmodule

// File: tb/tb_fpu_fetch_sequencer.sv
// Directed bench for fpu_fetch_sequencer: a default instance plus a 4-word
// instance for the end-of-memory case, each with a one-cycle-latency SRAM model.
module tb_fpu_fetch_sequencer;

   localparam logic [31:0] HALT = 32'h0010_0073;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, start, stall, fpu_done, start2;
   logic        mem_en, insn_valid, running, halted, timeout_err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rdata, insn, pc;
   logic        m2_mem_en, m2_insn_valid, m2_running, m2_halted, m2_timeout_err;
   logic [1:0]  m2_mem_addr;
   logic [31:0] m2_mem_rdata, m2_insn, m2_pc;

   logic [31:0] mem  [0:255];
   logic [31:0] mem2 [0:3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpu_fetch_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .insn(insn), .insn_valid(insn_valid), .stall(stall), .fpu_done(fpu_done),
      .pc(pc), .running(running), .halted(halted), .timeout_err(timeout_err)
   );

   fpu_fetch_sequencer #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .mem_en(m2_mem_en), .mem_addr(m2_mem_addr), .mem_rdata(m2_mem_rdata),
      .insn(m2_insn), .insn_valid(m2_insn_valid), .stall(1'b0), .fpu_done(1'b0),
      .pc(m2_pc), .running(m2_running), .halted(m2_halted), .timeout_err(m2_timeout_err)
   );

   // SRAM models: data valid the cycle after mem_en
   always @(posedge clk) begin
      if (mem_en)    mem_rdata    <= mem[mem_addr];
      if (m2_mem_en) m2_mem_rdata <= mem2[m2_mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
      mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Start and bring word 0 into its first WAIT_DONE cycle
   task automatic run_to_wait();
      pulse_start();
      tick();
      tick();
      stall = 1'b1;
      tick();
      tick();
      stall = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({mem_en, insn_valid, running, halted, timeout_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {mem_en, insn_valid, running, halted, timeout_err});
      end
      checks++;
      if ({pc, insn, mem_addr} !== 72'd0) begin
         errors++;
         $display("FAIL reset_regs: pc %h insn %h addr %h expected all zero", pc, insn, mem_addr);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: running %b expected 0", running);
      end
   endtask

   task automatic test_basic();
      load(NOP, NOP, NOP, HALT);
      pulse_start();
      checks++;
      if ({mem_en, running, mem_addr} !== {1'b1, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL basic_first_fetch: en %b run %b addr %0d expected 1 1 0",
                  mem_en, running, mem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({mem_en, insn_valid} !== 2'b00) begin
            errors++;
            $display("FAIL basic_read_%0d: en/valid %b expected 00", i, {mem_en, insn_valid});
         end
         tick();
         checks++;
         if ({insn_valid, pc, insn} !== {1'b1, 32'(4 * i), NOP}) begin
            errors++;
            $display("FAIL basic_issue_%0d: valid %b pc %h insn %h expected 1 %h %h",
                     i, insn_valid, pc, insn, 32'(4 * i), NOP);
         end
         tick();
         checks++;
         if (insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_check_%0d: valid %b expected 0", i, insn_valid);
         end
         tick();
         checks++;
         if ({mem_en, mem_addr, pc} !== {1'b1, 8'(i + 1), 32'(4 * (i + 1))}) begin
            errors++;
            $display("FAIL basic_fetch_%0d: en %b addr %0d pc %h expected 1 %0d %h",
                     i + 1, mem_en, mem_addr, pc, i + 1, 32'(4 * (i + 1)));
         end
      end
      tick();
      tick();
      checks++;
      if ({halted, running, insn_valid, mem_en} !== 4'b1000 || insn !== HALT || pc !== 32'd12) begin
         errors++;
         $display("FAIL basic_halt: h/r/v/en %b insn %h pc %h expected 1000 %h 0000000c",
                  {halted, running, insn_valid, mem_en}, insn, pc, HALT);
      end
      tick();
      tick();
      checks++;
      if ({halted, insn_valid, mem_en} !== 3'b100) begin
         errors++;
         $display("FAIL basic_halt_hold: h/v/en %b expected 100", {halted, insn_valid, mem_en});
      end
   endtask

   task automatic test_multicycle();
      load(NOP, NOP, HALT, NOP);
      run_to_wait();
      checks++;
      if (halted !== 1'b0 || running !== 1'b1) begin
         errors++;
         $display("FAIL multi_restart: halted %b running %b expected 0 1", halted, running);
      end
      for (int k = 1; k < 10; k++) begin
         checks++;
         if ({insn_valid, mem_en, pc} !== {2'b00, 32'd0}) begin
            errors++;
            $display("FAIL multi_wait_%0d: valid %b en %b pc %h expected 0 0 0", k, insn_valid, mem_en, pc);
         end
         tick();
      end
      fpu_done = 1'b1;
      tick();
      fpu_done = 1'b0;
      checks++;
      if ({mem_en, mem_addr, pc} !== {1'b1, 8'd1, 32'd4}) begin
         errors++;
         $display("FAIL multi_resume: en %b addr %0d pc %h expected 1 1 4", mem_en, mem_addr, pc);
      end
      tick();
      tick();
      checks++;
      if ({insn_valid, pc} !== {1'b1, 32'd4}) begin
         errors++;
         $display("FAIL multi_issue2: valid %b pc %h expected 1 4", insn_valid, pc);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if ({halted, pc} !== {1'b1, 32'd8}) begin
         errors++;
         $display("FAIL multi_halt: halted %b pc %h expected 1 8", halted, pc);
      end
   endtask

   task automatic test_watchdog();
      load(NOP, NOP, HALT, NOP);
      run_to_wait();
      for (int k = 1; k <= 255; k++) begin
         checks++;
         if ({timeout_err, running, pc} !== {2'b01, 32'd0}) begin
            errors++;
            $display("FAIL wdog_wait_%0d: err %b running %b pc %h expected 0 1 0", k, timeout_err, running, pc);
         end
         tick();
      end
      checks++;
      if ({timeout_err, halted, running, mem_en, pc} !== {4'b1000, 32'd0}) begin
         errors++;
         $display("FAIL wdog_fire: err/h/r/en %b pc %h expected 1000 0",
                  {timeout_err, halted, running, mem_en}, pc);
      end
      tick();
      tick();
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL wdog_sticky: err %b expected 1", timeout_err);
      end
      pulse_start();
      checks++;
      if ({timeout_err, mem_en, mem_addr, pc} !== {2'b01, 8'd0, 32'd0}) begin
         errors++;
         $display("FAIL wdog_restart: err %b en %b addr %0d pc %h expected 0 1 0 0",
                  timeout_err, mem_en, mem_addr, pc);
      end
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if ({halted, timeout_err} !== 2'b10) begin
         errors++;
         $display("FAIL wdog_rerun_halt: h/err %b expected 10", {halted, timeout_err});
      end
   endtask

   task automatic test_done_at_limit();
      load(NOP, NOP, HALT, NOP);
      run_to_wait();
      for (int k = 1; k < 255; k++) tick();
      fpu_done = 1'b1;
      tick();
      fpu_done = 1'b0;
      checks++;
      if ({timeout_err, mem_en, pc} !== {2'b01, 32'd4}) begin
         errors++;
         $display("FAIL limit_done: err %b en %b pc %h expected 0 1 4", timeout_err, mem_en, pc);
      end
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if ({halted, timeout_err, pc} !== {2'b10, 32'd8}) begin
         errors++;
         $display("FAIL limit_halt: h/err %b pc %h expected 10 8", {halted, timeout_err}, pc);
      end
   endtask

   task automatic test_spurious();
      load(NOP, NOP, HALT, NOP);
      pulse_start();
      fpu_done = 1'b1;
      tick();
      fpu_done = 1'b0;
      start = 1'b1;
      checks++;
      if ({mem_en, insn_valid, pc} !== {2'b00, 32'd0}) begin
         errors++;
         $display("FAIL spur_read: en %b valid %b pc %h expected 0 0 0", mem_en, insn_valid, pc);
      end
      tick();
      checks++;
      if ({insn_valid, pc, insn} !== {1'b1, 32'd0, NOP}) begin
         errors++;
         $display("FAIL spur_issue: valid %b pc %h insn %h expected 1 0 %h", insn_valid, pc, insn, NOP);
      end
      tick();
      start = 1'b0;
      checks++;
      if ({mem_en, insn_valid, pc} !== {2'b00, 32'd0}) begin
         errors++;
         $display("FAIL spur_check: en %b valid %b pc %h expected 0 0 0", mem_en, insn_valid, pc);
      end
      tick();
      checks++;
      if ({mem_en, mem_addr, pc} !== {1'b1, 8'd1, 32'd4}) begin
         errors++;
         $display("FAIL spur_fetch2: en %b addr %0d pc %h expected 1 1 4", mem_en, mem_addr, pc);
      end
      tick();
      tick();
      checks++;
      if ({insn_valid, pc} !== {1'b1, 32'd4}) begin
         errors++;
         $display("FAIL spur_issue2: valid %b pc %h expected 1 4", insn_valid, pc);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if ({halted, pc} !== {1'b1, 32'd8}) begin
         errors++;
         $display("FAIL spur_halt: halted %b pc %h expected 1 8", halted, pc);
      end
   endtask

   task automatic test_reset_midop();
      load(NOP, NOP, HALT, NOP);
      run_to_wait();
      tick();
      tick();
      rst      = 1'b1;
      fpu_done = 1'b1;
      tick();
      rst      = 1'b0;
      fpu_done = 1'b0;
      checks++;
      if ({mem_en, insn_valid, running, halted, timeout_err} !== 5'b0 || {pc, insn, mem_addr} !== 72'd0) begin
         errors++;
         $display("FAIL rst_mid: flags %b pc %h insn %h addr %h expected zeros",
                  {mem_en, insn_valid, running, halted, timeout_err}, pc, insn, mem_addr);
      end
      tick();
      tick();
      checks++;
      if ({mem_en, insn_valid, running} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_idle: en/valid/run %b expected 000", {mem_en, insn_valid, running});
      end
      pulse_start();
      checks++;
      if ({mem_en, mem_addr, pc} !== {1'b1, 8'd0, 32'd0}) begin
         errors++;
         $display("FAIL rst_mid_restart: en %b addr %0d pc %h expected 1 0 0", mem_en, mem_addr, pc);
      end
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if ({halted, pc} !== {1'b1, 32'd8}) begin
         errors++;
         $display("FAIL rst_mid_halt: halted %b pc %h expected 1 8", halted, pc);
      end
   endtask

   task automatic test_mem_end();
      for (int i = 0; i < 4; i++) mem2[i] = NOP;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({m2_mem_en, m2_mem_addr} !== {1'b1, 2'(i)}) begin
            errors++;
            $display("FAIL end_fetch_%0d: en %b addr %0d expected 1 %0d", i, m2_mem_en, m2_mem_addr, i);
         end
         tick();
         tick();
         checks++;
         if ({m2_insn_valid, m2_pc} !== {1'b1, 32'(4 * i)}) begin
            errors++;
            $display("FAIL end_issue_%0d: valid %b pc %h expected 1 %h", i, m2_insn_valid, m2_pc, 32'(4 * i));
         end
         tick();
         tick();
      end
      checks++;
      if ({m2_halted, m2_running, m2_mem_en, m2_pc} !== {3'b100, 32'd12}) begin
         errors++;
         $display("FAIL end_halt: h/r/en %b pc %h expected 100 c", {m2_halted, m2_running, m2_mem_en}, m2_pc);
      end
      tick();
      tick();
      checks++;
      if ({m2_mem_en, m2_insn_valid, m2_pc} !== {2'b00, 32'd12}) begin
         errors++;
         $display("FAIL end_no_wrap: en %b valid %b pc %h expected 0 0 c", m2_mem_en, m2_insn_valid, m2_pc);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      start2   = 1'b0;
      stall    = 1'b0;
      fpu_done = 1'b0;
      test_reset();
      test_basic();
      test_multicycle();
      test_watchdog();
      test_done_at_limit();
      test_spurious();
      test_reset_midop();
      test_mem_end();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
